// File: rtl/uart_rx_deserializer.sv
// ---------------------------------------------------------------------------
// uart_rx_deserializer
//
// Oversampling UART receiver. It resynchronises the serial line, frames the
// start bit, DATA_WIDTH data bits (LSB first), an optional parity bit and the
// stop bit. Each good byte goes to the downstream receive FIFO with a
// single-cycle write strobe.
//
// Parameters
//   DATA_WIDTH   : data bits per frame (5..9)
//   CLKS_PER_BIT : CLKip cycles per serial bit (even, >= 4)
//   PARITY_EN    : 1 = a parity bit follows the data bits
//   PARITY_ODD   : 0 = even parity, 1 = odd parity (only with PARITY_EN=1)
//
// Ports
//   CLKip  in   system clock
//   RSTi   in   asynchronous active-low reset
//   RXi    in   serial line, idle high, asynchronous to CLKip
//   FULLi  in   downstream FIFO full, sampled only at the stop-bit sample
//   DATAo  out  last accepted byte, changes only when VALIDo is high
//   VALIDo out  one-cycle FIFO write strobe for DATAo
//   BUSYo  out  a frame is in progress (FSM not in IDLE, BREAK included)
//   PERRo  out  one-cycle pulse on parity error
//   FERRo  out  one-cycle pulse on framing error (stop bit sampled low)
//   OVRo   out  one-cycle pulse when a good byte is dropped on FULLi
// ---------------------------------------------------------------------------
module uart_rx_deserializer #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned PARITY_ODD   = 0
) (
    input  logic                  CLKip,
    input  logic                  RSTi,
    input  logic                  RXi,
    input  logic                  FULLi,
    output logic [DATA_WIDTH-1:0] DATAo,
    output logic                  VALIDo,
    output logic                  BUSYo,
    output logic                  PERRo,
    output logic                  FERRo,
    output logic                  OVRo
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W = $clog2(DATA_WIDTH + 1);

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);
    localparam logic             HAS_PAR  = (PARITY_EN != 0);
    localparam logic             ODD_PAR  = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    state_t                state;
    logic [1:0]            sync;
    logic                  rx_s;
    logic [CNT_W-1:0]      cnt;
    logic [IDX_W-1:0]      idx;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  perr_l;

    // Two-flop synchronizer; reset to the idle (high) line level so a reset
    // release never looks like a start edge.
    always_ff @(posedge CLKip or negedge RSTi) begin
        if (!RSTi) begin
            sync <= '1;
        end else begin
            sync <= {sync[0], RXi};
        end
    end

    assign rx_s = sync[1];

    // Receive FSM. BUSYo is registered, so every transition also loads the
    // busy level of the state being entered.
    always_ff @(posedge CLKip or negedge RSTi) begin
        if (!RSTi) begin
            state  <= S_IDLE;
            cnt    <= '0;
            idx    <= '0;
            shreg  <= '0;
            perr_l <= 1'b0;
            DATAo  <= '0;
            VALIDo <= 1'b0;
            BUSYo  <= 1'b0;
            PERRo  <= 1'b0;
            FERRo  <= 1'b0;
            OVRo   <= 1'b0;
        end else begin
            VALIDo <= 1'b0;
            PERRo  <= 1'b0;
            FERRo  <= 1'b0;
            OVRo   <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (!rx_s) begin
                        state  <= S_START;
                        cnt    <= '0;
                        perr_l <= 1'b0;
                        BUSYo  <= 1'b1;
                    end
                end

                // Sample the middle of the start bit; a high level there is
                // a line glitch and is silently ignored.
                S_START: begin
                    if (cnt == CNT_HALF) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            state <= S_DATA;
                            idx   <= '0;
                        end else begin
                            state <= S_IDLE;
                            BUSYo <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                // Counting starts from mid start bit, so each full bit period
                // lands in the middle of the next bit.
                S_DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        shreg <= {rx_s, shreg[DATA_WIDTH-1:1]};
                        idx   <= idx + IDX_W'(1);
                        if (idx == IDX_LAST) begin
                            state <= HAS_PAR ? S_PARITY : S_STOP;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                // Mismatch = received bit differs from XOR of data (^ odd).
                S_PARITY: begin
                    if (cnt == CNT_LAST) begin
                        cnt    <= '0;
                        perr_l <= rx_s ^ (^shreg) ^ ODD_PAR;
                        state  <= S_STOP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                // Outcome priority: framing, parity, overrun, good byte.
                S_STOP: begin
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            FERRo <= 1'b1;
                            state <= S_BREAK;
                        end else begin
                            state <= S_IDLE;
                            BUSYo <= 1'b0;
                            if (perr_l) begin
                                PERRo <= 1'b1;
                            end else if (FULLi) begin
                                OVRo <= 1'b1;
                            end else begin
                                VALIDo <= 1'b1;
                                DATAo  <= shreg;
                            end
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                // Line stuck low after a framing error: wait quietly for idle.
                S_BREAK: begin
                    if (rx_s) begin
                        state <= S_IDLE;
                        BUSYo <= 1'b0;
                    end
                end

                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                    BUSYo <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_rx_deserializer.md
# uart_rx_deserializer

Asynchronous serial receiver for the UART receive path. It oversamples the RXi line, frames start, data, optional parity and stop bits, and writes each good byte into the receive FIFO with a single-cycle write strobe. The block sits directly upstream of the synchronous receive FIFO:

- VALIDo drives the FIFO write enable (WEi).
- DATAo drives the FIFO write data (DATAi).
- The FIFO full flag (FULLo) returns on FULLi.

## Interface

Parameters:

- DATA_WIDTH, 8: data bits per frame, range 5..9.
- CLKS_PER_BIT, 16: CLKip cycles per bit, even, ≥4.
- PARITY_EN, 0: 1 means a parity bit follows the data bits.
- PARITY_ODD, 0: 0 selects even parity, 1 selects odd. Ignored when PARITY_EN=0.

Ports:

- CLKip, in, 1: system clock.
- RSTi, in, 1: reset, asynchronous, active-low.
- RXi, in, 1: serial line, idle high. Asynchronous to CLKip.
- FULLi, in, 1: downstream FIFO full.
- DATAo, out, DATA_WIDTH: last accepted byte.
- VALIDo, out, 1: one-cycle write strobe for DATAo.
- BUSYo, out, 1: frame in progress (FSM not in IDLE).
- PERRo, out, 1: one-cycle pulse on parity error.
- FERRo, out, 1: one-cycle pulse on framing error.
- OVRo, out, 1: one-cycle pulse on overrun.

## Operation

- **Synchronizer.** RXi passes through a 2-flop synchronizer to give rx_s. Synchronizer flops reset to 1.
- **Counters.** Bit counter cnt is $clog2(CLKS_PER_BIT) bits wide. Bit index idx is $clog2(DATA_WIDTH+1) bits wide. A shift register holds DATA_WIDTH bits.
- **IDLE.**
  - If rx_s==0 → START, cnt=0.
  - Otherwise stay in IDLE.
- **START.**
  - Increment cnt each cycle.
  - At cnt==CLKS_PER_BIT/2-1, sample rx_s:
    - 0 → DATA, cnt=0, idx=0.
    - 1 → glitch: return to IDLE. No output, no error.
- **DATA.**
  - Increment cnt. At cnt==CLKS_PER_BIT-1, sample rx_s into the shift register, LSB first, and set cnt=0, idx++.
  - After DATA_WIDTH samples → PARITY if PARITY_EN, else STOP.
- **PARITY.** At cnt==CLKS_PER_BIT-1, sample the bit. Expected value is XOR of the data bits, inverted if PARITY_ODD. Latch mismatch as perr_l. Then → STOP.
- **STOP.** At cnt==CLKS_PER_BIT-1, sample rx_s. Priority at this sample:
  1. rx_s==0: FERRo pulse, VALIDo=0 → BREAK.
  2. else perr_l: PERRo pulse, byte discarded → IDLE.
  3. else FULLi==1: OVRo pulse, byte discarded, DATAo unchanged → IDLE.
  4. else: DATAo←shift register, VALIDo pulse → IDLE.
- **BREAK.** Wait until rx_s==1, then → IDLE. No further errors are reported while waiting.
- **Register rules.**
  - At most one of VALIDo, PERRo, FERRo, OVRo is high in any cycle.
  - DATAo changes only on a VALIDo cycle and holds otherwise.
  - perr_l clears on entry to START.

## Timing

- **Reset values.** DATAo=0, VALIDo=0, BUSYo=0, PERRo=0, FERRo=0, OVRo=0. FSM=IDLE, cnt=0, idx=0, perr_l=0.
- **Reset mid-frame.** The partial frame is dropped with no pulses. After release, the block waits for a new falling edge on rx_s.
- **Synchronizer latency.** rx_s lags RXi by 2 cycles.
- **Sample cycles.** Let cycle H be the first IDLE cycle with rx_s==0.
  - Start-bit sample: H+CLKS_PER_BIT/2.
  - Data bit k sample: H+CLKS_PER_BIT/2+(k+1)·CLKS_PER_BIT.
- **Output timing.** All outputs are registered. VALIDo and the error pulses are high for exactly the cycle after the stop-bit sample:
  - H + CLKS_PER_BIT/2 + (DATA_WIDTH+1+PARITY_EN)·CLKS_PER_BIT + 1.
  - Default 8N1 at 16 clocks per bit: H+153.
- **Back-to-back frames.** The FSM is back in IDLE in the same cycle VALIDo is asserted. A start edge arriving during the second half of the stop bit is detected with no lost frame.
- **BUSYo.** Registered. High in every non-IDLE state, including BREAK.
- **FULLi.** Sampled only at the stop-bit sample cycle. FULLi changes at any other time have no effect.

## Test plan

- **Good byte.** Defaults; send 0xA5 8N1 at 16 clocks per bit → one VALIDo pulse at H+153 with DATAo=0xA5. No error pulses. BUSYo low afterwards.
- **Back-to-back.** Send 0x00, 0xFF, 0x55 with no idle gap → three VALIDo pulses exactly 160 cycles apart, with DATAo = 0x00, 0xFF, 0x55.
- **Parity.** PARITY_EN=1, PARITY_EVEN (PARITY_ODD=0).
  - Send 0x03 with parity bit 1 → PERRo pulse, no VALIDo, DATAo unchanged.
  - Send 0x03 with parity bit 0 → VALIDo with DATAo=0x03.
- **Framing error and glitch.**
  - Stop bit driven 0, line held low for 40 bits → one FERRo pulse; BUSYo stays high until the line returns high. The next 0x3C is received correctly.
  - A 4-cycle low glitch on an idle line → no outputs, BUSYo back low.
- **Overrun.** Hold FULLi=1 across the stop-bit sample of 0x7E → OVRo pulse, no VALIDo, DATAo keeps its previous value. With FULLi=0, the next 0x81 → VALIDo with DATAo=0x81.
- **Reset mid-frame.** Assert RSTi low mid-way through data bit 4 → all outputs 0 immediately (asynchronous). Release, then send 0x96 → VALIDo with DATAo=0x96 and no spurious pulses.
